mem_bridge: RTL and testbench

Memory access bridge between the multicycle RISC-V core (controller + datapath) and a variable-latency unified instruction/data memory bus. It converts the core's single-cycle memory accesses into a req/ack bus transaction and stalls the core while the access is outstanding. It holds the Instruction register and the read-Data register that the datapath consumes. The stall output gates the clock enable of the controller state register and all datapath enables.

---
 rtl/mem_bridge.sv | 123 ++++++++++++
 tb/tb_mem_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// Memory access bridge: turns single-cycle core accesses into a req/ack bus transaction and
// stalls the core while it is outstanding. Optional bus timeout: define MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acc_valid,
    input  logic        acc_write,
    input  logic        acc_fetch,
    input  logic [31:0] acc_adr,
    input  logic [31:0] acc_wdata,
    output logic        stall,
    output logic [31:0] instr,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_write_q;
    logic        req_fetch_q;
    logic [31:0] req_adr_q;
    logic [31:0] req_wdata_q;
    logic [31:0] instr_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        ack_busy;
    logic        timeout_hit;

    assign accept   = (state_q == ST_IDLE) && acc_valid;
    assign ack_busy = (state_q == ST_BUSY) && bus_ack;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // Counter sits at zero outside BUSY, so it is already cleared on BUSY entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_BUSY) && !bus_ack && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc_valid) state_d = ST_BUSY;
            ST_BUSY: if (bus_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_write_q <= 1'b0;
            req_fetch_q <= 1'b0;
            req_adr_q   <= '0;
            req_wdata_q <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_write_q <= acc_write;
                req_fetch_q <= acc_fetch;
                req_adr_q   <= acc_adr & 32'hFFFF_FFFC;
                req_wdata_q <= acc_wdata;
            end
            if (ack_busy && req_fetch_q) begin
                instr_q <= bus_rdata;
            end
            if (ack_busy && !req_fetch_q && !req_write_q) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    assign stall     = accept || (state_q == ST_BUSY);
    assign bus_req   = (state_q == ST_BUSY);
    assign bus_we    = req_write_q;
    assign bus_adr   = req_adr_q;
    assign bus_wdata = req_wdata_q;
    assign instr     = instr_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: scoreboard of expected bus transactions plus a model of
// the instruction/read-data registers. Timeout scenario runs when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_bridge;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        acc_valid, acc_write, acc_fetch;
    logic [31:0] acc_adr, acc_wdata;
    logic        stall;
    logic [31:0] instr, rdata;
    logic        err;
    logic        bus_req, bus_we;
    logic [31:0] bus_adr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .acc_valid(acc_valid), .acc_write(acc_write), .acc_fetch(acc_fetch),
        .acc_adr(acc_adr), .acc_wdata(acc_wdata),
        .stall(stall), .instr(instr), .rdata(rdata), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    logic        have_item = 1'b0;
    int          busy_cnt = 0;
    int          n_txn = 0;
    logic        spur_ack = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    // Bus-side responder: pops the expected transaction on its first BUSY cycle, checks the
    // bus fields every BUSY cycle and acks after the scheduled number of wait cycles.
    always @(negedge clk) begin
        if (bus_req) begin
            if (!have_item) begin
                n_txn++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_bus_req: adr=%h with empty scoreboard", bus_adr);
                    cur = '{bus_we, bus_adr, bus_wdata, 0, 32'h0};
                end else begin
                    cur = exp_q.pop_front();
                end
                have_item = 1'b1;
                busy_cnt  = 0;
            end
            n_tests++;
            if ({bus_we, bus_adr, bus_wdata} !== {cur.we, cur.adr, cur.wdata}) begin
                n_fail++;
                $display("FAIL bus_fields: got we=%b adr=%h wdata=%h, want we=%b adr=%h wdata=%h",
                         bus_we, bus_adr, bus_wdata, cur.we, cur.adr, cur.wdata);
            end
            bus_ack   = (busy_cnt == cur.waits);
            bus_rdata = bus_ack ? cur.rdata : $urandom;
            busy_cnt++;
        end else begin
            have_item = 1'b0;
            bus_ack   = spur_ack;
            bus_rdata = $urandom;
        end
    end

    task automatic check_regs(input string name);
        n_tests++;
        if ({instr, rdata, err} !== {m_instr, m_rdata, m_err}) begin
            n_fail++;
            $display("FAIL %s regs: got instr=%h rdata=%h err=%b, want instr=%h rdata=%h err=%b",
                     name, instr, rdata, err, m_instr, m_rdata, m_err);
        end
    endtask

    // One core access; acc_valid is left high through the DONE cycle, as the core does.
    task automatic access(input logic wr, input logic fe, input logic [31:0] adr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd,
                          input string name);
        logic to;
        int   exp_stall;
        int   stall_cnt;
        logic done;
        to = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        if (waits >= TIMEOUT) to = 1'b1;
`endif
        exp_stall = to ? TIMEOUT + 1 : waits + 2;
        exp_q.push_back('{wr, adr & 32'hFFFF_FFFC, wd, waits, rd});
        if (to) m_err = 1'b1;
        else if (fe) m_instr = rd;
        else if (!wr) m_rdata = rd;

        @(negedge clk);
        acc_valid = 1'b1; acc_write = wr; acc_fetch = fe; acc_adr = adr; acc_wdata = wd;
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stall_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (!done || stall_cnt != exp_stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d (ended=%b), want %0d", name, stall_cnt, done, exp_stall);
        end
        n_tests++;
        if (bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_bus_req: got %b, want 0", name, bus_req);
        end
        check_regs(name);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        acc_valid = 1'b0; acc_write = 1'b0; acc_fetch = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        acc_valid = 1'b1;
        #1;
        n_tests++;
        if ({bus_req, bus_we, bus_adr, bus_wdata, instr, rdata, err} !== '0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b we=%b adr=%h wd=%h instr=%h rdata=%h err=%b stall=%b, want zeros stall=1",
                     bus_req, bus_we, bus_adr, bus_wdata, instr, rdata, err, stall);
        end
        acc_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got stall=%b req=%b, want 0 0", stall, bus_req);
        end
    endtask

    task automatic test_fetch();
        access(1'b0, 1'b1, 32'h0000_0004, 32'h0, 0, 32'h0062_E233, "fetch_zero_wait");
        idle(2);
    endtask

    task automatic test_read_wait();
        access(1'b0, 1'b0, 32'h0000_0013, 32'h0, 3, 32'hDEAD_BEEF, "read_3_waits");
        idle(2);
    endtask

    task automatic test_write();
        access(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 2, 32'hA5A5_A5A5, "write");
        idle(2);
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_txn;
        access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_2222, "b2b_read");
        access(1'b0, 1'b1, 32'h0000_0108, 32'h0, 0, 32'h3333_4444, "b2b_fetch");
        idle(3);
        n_tests++;
        if (n_txn - base != 2) begin
            n_fail++;
            $display("FAIL b2b_txn_count: got %0d, want 2", n_txn - base);
        end
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        spur_ack = 1'b0;
        n_tests++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || n_txn - base != 2) begin
            n_fail++;
            $display("FAIL spurious_ack: got req=%b stall=%b txns=%0d, want 0 0 2", bus_req, stall, n_txn - base);
        end
        check_regs("spurious_ack");
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back('{1'b0, 32'h0000_0040, 32'h0, 1000, 32'h0});
        @(negedge clk);
        acc_valid = 1'b1; acc_write = 1'b0; acc_fetch = 1'b0; acc_adr = 32'h0000_0040;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: got req=%b, want 1", bus_req);
        end
        acc_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        m_instr = '0; m_rdata = '0; m_err = 1'b0;
        n_tests++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || bus_adr !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_drop: got req=%b stall=%b adr=%h, want 0 0 0", bus_req, stall, bus_adr);
        end
        check_regs("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got req=%b stall=%b, want 0 0", bus_req, stall);
        end
        access(1'b0, 1'b1, 32'h0000_0044, 32'h0, 0, 32'h0BAD_F00D, "after_reset_fetch");
        idle(2);
    endtask

    task automatic test_timeout();
`ifdef MEM_BRIDGE_TIMEOUT_EN
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1000, 32'hFFFF_0000, "timeout");
        idle(2);
        access(1'b0, 1'b0, 32'h0000_0084, 32'h0, 1, 32'h5555_AAAA, "err_sticky");
        idle(2);
`else
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, 20, 32'h7777_8888, "long_wait_no_timeout");
        idle(2);
`endif
    endtask

    initial begin
        reset = 1'b1;
        acc_valid = 1'b0; acc_write = 1'b0; acc_fetch = 1'b0;
        acc_adr = '0; acc_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        test_reset();
        test_fetch();
        test_read_wait();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
